// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if: host-side bus of uart_ctrl
//   master (host): dvsr, wr_uart, w_data, rd_uart, err_clr
//   slave (uart):  r_data, tx_full, rx_empty, tx_busy, tx_done_tick, rx_done_tick,
//                  rx_overrun, rx_frame_err, rx_parity_err
interface uart_ctrl_if #(
    parameter int DBIT     = 8,
    parameter int DVSR_BIT = 11
);
    logic [DVSR_BIT-1:0] dvsr;
    logic                wr_uart;
    logic [DBIT-1:0]     w_data;
    logic                rd_uart;
    logic                err_clr;
    logic [DBIT-1:0]     r_data;
    logic                tx_full;
    logic                rx_empty;
    logic                tx_busy;
    logic                tx_done_tick;
    logic                rx_done_tick;
    logic                rx_overrun;
    logic                rx_frame_err;
    logic                rx_parity_err;

    modport master(
        output dvsr, wr_uart, w_data, rd_uart, err_clr,
        input  r_data, tx_full, rx_empty, tx_busy, tx_done_tick, rx_done_tick,
               rx_overrun, rx_frame_err, rx_parity_err
    );

    modport slave(
        input  dvsr, wr_uart, w_data, rd_uart, err_clr,
        output r_data, tx_full, rx_empty, tx_busy, tx_done_tick, rx_done_tick,
               rx_overrun, rx_frame_err, rx_parity_err
    );
endinterface

// File: rtl/uart_ctrl.sv
// uart_ctrl: UART with runtime baud divisor, optional parity and TX/RX FIFOs
//   clk   system clock, rising edge
//   reset asynchronous, active-high
//   rx    serial input (idle high, asynchronous)
//   tx    serial output (registered)
//   bus   host bus (uart_ctrl_if.slave): divisor, FIFO access, status, pulses, sticky errors
module uart_ctrl #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int PARITY   = 0,
    parameter int DVSR_BIT = 11,
    parameter int FIFO_W   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    uart_ctrl_if.slave bus
);
    localparam int              DEPTH   = 2 ** FIFO_W;
    localparam logic [FIFO_W:0] FULL    = (FIFO_W + 1)'(DEPTH);
    localparam logic [4:0]      SB_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0]      N_LAST  = 3'(DBIT - 1);
    localparam logic            PODD    = PARITY == 2;
    localparam logic            PEN     = PARITY != 0;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    // free-running baud counter; >= lets a smaller dvsr wrap immediately
    logic [DVSR_BIT-1:0] b_cnt, lim;
    logic                tick;
    assign lim  = (bus.dvsr == '0) ? DVSR_BIT'(1) : bus.dvsr;
    assign tick = b_cnt >= lim - DVSR_BIT'(1);

    always_ff @(posedge clk or posedge reset)
        if (reset) b_cnt <= '0;
        else b_cnt <= tick ? '0 : b_cnt + DVSR_BIT'(1);

    logic [1:0] sync;
    logic       rx_s;
    assign rx_s = sync[1];

    always_ff @(posedge clk or posedge reset)
        if (reset) sync <= 2'b11;
        else sync <= {sync[0], rx};

    // FIFOs: count-based full/empty, a read frees the slot for a same-cycle write
    logic [DBIT-1:0]   tx_mem [DEPTH];
    logic [DBIT-1:0]   rx_mem [DEPTH];
    logic [FIFO_W-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [FIFO_W:0]   tx_n, rx_n;
    logic              tx_empty, tx_pop, tx_wr, rx_push, rx_wr, rx_rd;
    logic [DBIT-1:0]   rx_b, rx_b_n;

    assign tx_empty     = tx_n == '0;
    assign bus.tx_full  = tx_n == FULL;
    assign tx_wr        = bus.wr_uart & (~bus.tx_full | tx_pop);
    assign bus.rx_empty = rx_n == '0;
    assign rx_rd        = bus.rd_uart & ~bus.rx_empty;
    assign rx_wr        = rx_push & ((rx_n != FULL) | rx_rd);
    assign bus.r_data   = rx_mem[rx_rp];

    always_ff @(posedge clk) begin
        if (tx_wr) tx_mem[tx_wp] <= bus.w_data;
        if (rx_wr) rx_mem[rx_wp] <= rx_b;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            tx_wp <= '0;
            tx_rp <= '0;
            tx_n  <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
            rx_n  <= '0;
        end else begin
            tx_wp <= tx_wp + FIFO_W'(tx_wr);
            tx_rp <= tx_rp + FIFO_W'(tx_pop);
            tx_n  <= tx_n + (FIFO_W + 1)'(tx_wr) - (FIFO_W + 1)'(tx_pop);
            rx_wp <= rx_wp + FIFO_W'(rx_wr);
            rx_rp <= rx_rp + FIFO_W'(rx_rd);
            rx_n  <= rx_n + (FIFO_W + 1)'(rx_wr) - (FIFO_W + 1)'(rx_rd);
        end

    // TX FSM: tick counter wraps at the end of each bit; tx is driven from next-state values
    state_t          tx_st, tx_st_n;
    logic [4:0]      tx_c, tx_c_n;
    logic [2:0]      tx_i, tx_i_n;
    logic [DBIT-1:0] tx_b, tx_b_n;
    logic            tx_p, tx_p_n, tx_last, tx_end, tx_d;

    assign tx_last     = tx_c == ((tx_st == STOP) ? SB_LAST : 5'd15);
    assign tx_end      = tick & tx_last;
    assign bus.tx_busy = tx_st != IDLE;
    assign tx_d        = (tx_st_n == START) ? 1'b0 :
                         (tx_st_n == DATA)  ? tx_b_n[0] :
                         (tx_st_n == PAR)   ? tx_p_n : 1'b1;

    always_comb begin
        tx_st_n          = tx_st;
        tx_c_n           = tick ? (tx_last ? '0 : tx_c + 5'd1) : tx_c;
        tx_i_n           = tx_i;
        tx_b_n           = tx_b;
        tx_p_n           = tx_p;
        tx_pop           = 1'b0;
        bus.tx_done_tick = 1'b0;
        case (tx_st)
            IDLE: if (!tx_empty) begin
                tx_pop  = 1'b1;
                tx_b_n  = tx_mem[tx_rp];
                tx_p_n  = ^tx_mem[tx_rp] ^ PODD;
                tx_c_n  = '0;
                tx_st_n = START;
            end
            START: if (tx_end) begin
                tx_i_n  = '0;
                tx_st_n = DATA;
            end
            DATA: if (tx_end) begin
                tx_b_n = tx_b >> 1;
                tx_i_n = tx_i + 3'd1;
                if (tx_i == N_LAST) tx_st_n = PEN ? PAR : STOP;
            end
            PAR: if (tx_end) tx_st_n = STOP;
            STOP: if (tx_end) begin
                bus.tx_done_tick = 1'b1;
                tx_st_n          = IDLE;
            end
            default: tx_st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            tx_st <= IDLE;
            tx_c  <= '0;
            tx_i  <= '0;
            tx_b  <= '0;
            tx_p  <= 1'b0;
            tx    <= 1'b1;
        end else begin
            tx_st <= tx_st_n;
            tx_c  <= tx_c_n;
            tx_i  <= tx_i_n;
            tx_b  <= tx_b_n;
            tx_p  <= tx_p_n;
            tx    <= tx_d;
        end

    // RX FSM: start waits 8 ticks to the bit centre, later bits are 16 ticks apart
    state_t     rx_st, rx_st_n;
    logic [4:0] rx_c, rx_c_n;
    logic [2:0] rx_i, rx_i_n;
    logic       rx_last, rx_end, fe_set, pe_set;

    assign rx_last = rx_c == ((rx_st == START) ? 5'd7 : (rx_st == STOP) ? SB_LAST : 5'd15);
    assign rx_end  = tick & rx_last;

    always_comb begin
        rx_st_n          = rx_st;
        rx_c_n           = tick ? (rx_last ? '0 : rx_c + 5'd1) : rx_c;
        rx_i_n           = rx_i;
        rx_b_n           = rx_b;
        rx_push          = 1'b0;
        fe_set           = 1'b0;
        pe_set           = 1'b0;
        bus.rx_done_tick = 1'b0;
        case (rx_st)
            IDLE: if (!rx_s) begin
                rx_c_n  = '0;
                rx_st_n = START;
            end
            START: begin
                rx_i_n = '0;
                if (rx_end) rx_st_n = rx_s ? IDLE : DATA;
            end
            DATA: if (rx_end) begin
                rx_b_n = {rx_s, rx_b[DBIT-1:1]};
                rx_i_n = rx_i + 3'd1;
                if (rx_i == N_LAST) rx_st_n = PEN ? PAR : STOP;
            end
            PAR: if (rx_end) begin
                pe_set  = rx_s != (^rx_b ^ PODD);
                rx_st_n = STOP;
            end
            STOP: if (rx_end) begin
                bus.rx_done_tick = 1'b1;
                fe_set           = ~rx_s;
                rx_push          = 1'b1;
                rx_st_n          = IDLE;
            end
            default: rx_st_n = IDLE;
        endcase
    end

    // sticky flags: a set wins over a same-cycle err_clr
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rx_st             <= IDLE;
            rx_c              <= '0;
            rx_i              <= '0;
            rx_b              <= '0;
            bus.rx_overrun    <= 1'b0;
            bus.rx_frame_err  <= 1'b0;
            bus.rx_parity_err <= 1'b0;
        end else begin
            rx_st             <= rx_st_n;
            rx_c              <= rx_c_n;
            rx_i              <= rx_i_n;
            rx_b              <= rx_b_n;
            bus.rx_overrun    <= (rx_push & ~rx_wr) | (bus.rx_overrun & ~bus.err_clr);
            bus.rx_frame_err  <= fe_set | (bus.rx_frame_err & ~bus.err_clr);
            bus.rx_parity_err <= pe_set | (bus.rx_parity_err & ~bus.err_clr);
        end
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: self-checking bench for uart_ctrl (DBIT=8, even parity, 1 stop bit, dvsr=4)
module tb_uart_ctrl;
    localparam int BIT = 64;
    localparam int DEPTH = 4;

    logic clk = 1'b0, reset = 1'b1, loop = 1'b0, rx_drv = 1'b1;
    logic rx, tx;
    int   checks = 0, errors = 0, rx_cnt = 0, tx_cnt = 0;
    logic [9:0] dq[$];

    uart_ctrl_if #(.DBIT(8), .DVSR_BIT(11)) bus();
    assign rx = loop ? tx : rx_drv;

    uart_ctrl #(.DBIT(8), .SB_TICK(16), .PARITY(1), .DVSR_BIT(11), .FIFO_W(2)) dut (
        .clk(clk), .reset(reset), .rx(rx), .tx(tx), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_done_tick === 1'b1) rx_cnt++;
        if (bus.tx_done_tick === 1'b1) tx_cnt++;
    end

    // line decoder on tx: {stop ok & start ok, even parity ok, data}
    initial begin : dec
        logic [7:0] d;
        logic p, ok;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (BIT / 2) @(negedge clk);
                ok = tx === 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    d[i] = tx;
                end
                repeat (BIT) @(negedge clk);
                p = tx;
                repeat (BIT) @(negedge clk);
                dq.push_back({tx & ok, p == ^d, d});
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic line(input logic v, input int n);
        rx_drv = v;
        cyc(n);
    endtask

    task automatic send(input logic [7:0] d, input bit bp, input bit bs);
        line(1'b0, BIT);
        for (int i = 0; i < 8; i++) line(d[i], BIT);
        line(^d ^ bp, BIT);
        if (bs) begin
            line(1'b0, 48);
            line(1'b1, 80);
        end else line(1'b1, BIT + 16);
    endtask

    task automatic wait_rx(input int target, input string nm);
        int k = 0;
        while (rx_cnt < target && k < 2000) begin
            cyc(1);
            k++;
        end
        chk(nm, 32'(rx_cnt >= target), 1);
    endtask

    task automatic pop();
        bus.rd_uart = 1'b1;
        cyc(1);
        bus.rd_uart = 1'b0;
    endtask

    task automatic clr();
        bus.err_clr = 1'b1;
        cyc(1);
        bus.err_clr = 1'b0;
    endtask

    task automatic write(input logic [7:0] d);
        bus.w_data  = d;
        bus.wr_uart = 1'b1;
        cyc(1);
        bus.wr_uart = 1'b0;
    endtask

    typedef struct {
        logic [7:0] d;
        bit         bp;
        bit         bs;
        logic [7:0] ed;
        bit         efe;
        bit         epe;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [7:0] mq[$];
        logic [7:0] w[6];
        logic [7:0] d;
        bit   bp, ovr;
        int   base, bt, n0, gap, maxgap, k;

        vt[0] = '{8'hA5, 0, 0, 8'hA5, 0, 0};
        vt[1] = '{8'h3C, 0, 1, 8'h3C, 1, 0};
        vt[2] = '{8'h5A, 1, 0, 8'h5A, 0, 1};
        vt[3] = '{8'h00, 0, 0, 8'h00, 0, 0};
        vt[4] = '{8'hFF, 1, 1, 8'hFF, 1, 1};
        vt[5] = '{8'h81, 0, 0, 8'h81, 0, 0};

        bus.dvsr    = 11'd4;
        bus.wr_uart = 1'b0;
        bus.w_data  = '0;
        bus.rd_uart = 1'b0;
        bus.err_clr = 1'b0;
        cyc(3);
        chk("rst_tx", tx, 1);
        chk("rst_busy", bus.tx_busy, 0);
        chk("rst_txdone", bus.tx_done_tick, 0);
        chk("rst_rxdone", bus.rx_done_tick, 0);
        chk("rst_full", bus.tx_full, 0);
        chk("rst_empty", bus.rx_empty, 1);
        chk("rst_flags", {bus.rx_overrun, bus.rx_frame_err, bus.rx_parity_err}, 0);
        reset = 1'b0;
        cyc(20);
        chk("rst_no_done", rx_cnt, 0);

        foreach (vt[i]) begin
            base = rx_cnt;
            send(vt[i].d, vt[i].bp, vt[i].bs);
            wait_rx(base + 1, "vec_timeout");
            cyc(BIT);
            chk("vec_done", rx_cnt - base, 1);
            chk("vec_data", bus.r_data, vt[i].ed);
            chk("vec_fe", bus.rx_frame_err, vt[i].efe);
            chk("vec_pe", bus.rx_parity_err, vt[i].epe);
            pop();
            chk("vec_empty", bus.rx_empty, 1);
            clr();
            chk("vec_clr", {bus.rx_frame_err, bus.rx_parity_err}, 0);
        end

        loop = 1'b1;
        base = rx_cnt;
        write(8'hA5);
        wait_rx(base + 1, "lb_timeout");
        cyc(BIT);
        chk("lb_done", rx_cnt - base, 1);
        chk("lb_data", bus.r_data, 8'hA5);
        chk("lb_empty", bus.rx_empty, 0);
        chk("lb_flags", {bus.rx_overrun, bus.rx_frame_err, bus.rx_parity_err}, 0);
        pop();

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            mq.push_back(d);
            base = rx_cnt;
            write(d);
            wait_rx(base + 1, "rlb_timeout");
            cyc(4);
            chk("rlb_data", bus.r_data, mq.pop_front());
            chk("rlb_flags", {bus.rx_frame_err, bus.rx_parity_err}, 0);
            pop();
        end

        loop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d  = 8'($urandom);
            bp = 1'($urandom_range(0, 1));
            base = rx_cnt;
            send(d, bp, 0);
            wait_rx(base + 1, "rrx_timeout");
            cyc(4);
            chk("rrx_data", bus.r_data, d);
            chk("rrx_pe", bus.rx_parity_err, bp);
            chk("rrx_fe", bus.rx_frame_err, 0);
            pop();
            clr();
        end

        base = rx_cnt;
        line(1'b0, 20);
        line(1'b1, 400);
        chk("glitch_done", rx_cnt - base, 0);
        chk("glitch_empty", bus.rx_empty, 1);
        send(8'h69, 0, 0);
        wait_rx(base + 1, "glitch_timeout");
        cyc(4);
        chk("glitch_next", bus.r_data, 8'h69);
        pop();

        base = rx_cnt;
        ovr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w[i] = 8'($urandom);
            send(w[i], 0, 0);
            wait_rx(base + i + 1, "ovr_timeout");
            if (mq.size() < DEPTH) mq.push_back(w[i]);
            else ovr = 1'b1;
        end
        cyc(4);
        chk("ovr_flag", bus.rx_overrun, ovr);
        chk("ovr_done", rx_cnt - base, 5);
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovr_word", bus.r_data, mq.pop_front());
            pop();
        end
        chk("ovr_empty", bus.rx_empty, 1);
        clr();
        chk("ovr_clr", bus.rx_overrun, 0);

        bt = tx_cnt;
        n0 = dq.size();
        for (int i = 0; i < 6; i++) begin
            w[i] = 8'($urandom);
            if (i == 4) chk("full_before5", bus.tx_full, 0);
            if (i == 5) chk("full_after5", bus.tx_full, 1);
            bus.w_data  = w[i];
            bus.wr_uart = 1'b1;
            cyc(1);
        end
        bus.wr_uart = 1'b0;
        gap = 0;
        maxgap = 0;
        k = 0;
        while (tx_cnt < bt + 5 && k < 5000) begin
            cyc(1);
            k++;
            if (!bus.tx_busy) gap++;
            else begin
                if (gap > maxgap) maxgap = gap;
                gap = 0;
            end
        end
        chk("tx_timeout", 32'(tx_cnt >= bt + 5), 1);
        chk("tx_gap", 32'(maxgap <= 1), 1);
        cyc(3 * BIT);
        chk("tx_frames", tx_cnt - bt, 5);
        chk("tx_idle", bus.tx_busy, 0);
        chk("tx_decoded", dq.size() - n0, 5);
        for (int i = 0; i < 5; i++)
            if (n0 + i < dq.size()) chk("tx_word", dq[n0 + i], {2'b11, w[i]});

        base = rx_cnt;
        send(8'h33, 0, 0);
        wait_rx(base + 1, "pre_rst_timeout");
        chk("pre_rst_empty", bus.rx_empty, 0);
        loop = 1'b1;
        write(8'h0F);
        write(8'hF0);
        cyc(BIT + 100);
        chk("pre_rst_busy", bus.tx_busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", bus.tx_busy, 0);
        chk("mid_rst_empty", bus.rx_empty, 1);
        chk("mid_rst_full", bus.tx_full, 0);
        cyc(2);
        reset = 1'b0;
        bt = tx_cnt;
        base = rx_cnt;
        cyc(15 * BIT);
        chk("post_rst_txdone", tx_cnt - bt, 0);
        chk("post_rst_rxdone", rx_cnt - base, 0);
        chk("post_rst_tx", tx, 1);
        chk("post_rst_empty", bus.rx_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
